// File: rtl/mult_lane_arbiter_pkg.sv
// Shared types and constants for the multiplier lane arbiter.
// Operands and results are Q16 fixed point; FIX_ONE is 1.0.
package mult_arb_pkg;

  localparam int DW        = 36;
  localparam int LANES     = 6;
  localparam int OWN_W     = 3;
  localparam int REQ_SLOTS = 1 << OWN_W;

  localparam logic [DW-1:0] FIX_ONE = 36'd65536;

  typedef logic [DW-1:0]          word_t;
  typedef word_t [LANES-1:0]      lane_vec_t;

  typedef struct packed {
    logic             valid;
    logic [OWN_W-1:0] owner;
    logic             last;
  } tag_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

endpackage

// File: rtl/mult_lane_arbiter_tag_pipe.sv
// Ownership tags travelling alongside the multiplier pipeline.
// DEPTH covers the operand register plus the multiplier latency.
module mult_tag_pipe
  import mult_arb_pkg::*;
#(
  parameter int DEPTH = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  tag_t i_tag,
  output tag_t o_tag
);

  tag_t [DEPTH-1:0] r_pipe;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pipe <= '0;
    end else if (en) begin
      r_pipe[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_tag = r_pipe[DEPTH-1];

endmodule

// File: rtl/mult_lane_arbiter.sv
// Round-robin burst arbiter sharing one LANES-wide pipelined multiplier among N_REQ requesters.
// Result beats are routed back to their owner by a tag pipe matched to the multiplier latency.
module mult_lane_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MULT_LAT = 4,
  parameter int MAX_LEN  = 8,
  parameter int LEN_W    = $clog2(MAX_LEN + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*LEN_W-1:0]    req_len,
  input  logic [N_REQ*LANES*DW-1:0] req_dataa,
  input  logic [N_REQ*LANES*DW-1:0] req_datab,
  output logic [N_REQ-1:0]          grant,
  output logic [LANES*DW-1:0]       mult_dataa,
  output logic [LANES*DW-1:0]       mult_datab,
  input  logic [LANES*DW-1:0]       mult_result,
  output logic [LANES*DW-1:0]       res_data,
  output logic [N_REQ-1:0]          res_valid,
  output logic                      res_last
);

  state_t           r_state;
  logic [OWN_W-1:0] r_rr;
  logic [OWN_W-1:0] r_owner;
  logic [LEN_W-1:0] r_beats_left;
  lane_vec_t        r_dataa;
  lane_vec_t        r_datab;

  // Requesters widened to a power-of-two slot count so owner ids index them directly.
  logic [REQ_SLOTS-1:0]            w_req_ext;
  logic [REQ_SLOTS-1:0][LEN_W-1:0] w_len_arr;
  lane_vec_t [REQ_SLOTS-1:0]       w_dataa_arr;
  lane_vec_t [REQ_SLOTS-1:0]       w_datab_arr;

  logic [OWN_W-1:0] w_winner;
  logic [OWN_W-1:0] w_src;
  logic [LEN_W-1:0] w_len_raw;
  logic [LEN_W-1:0] w_len;
  logic             w_beat;
  logic             w_last;
  tag_t             w_tag_in;
  tag_t             w_tag_out;

  assign w_req_ext   = REQ_SLOTS'(req);
  assign w_len_arr   = (REQ_SLOTS*LEN_W)'(req_len);
  assign w_dataa_arr = (REQ_SLOTS*LANES*DW)'(req_dataa);
  assign w_datab_arr = (REQ_SLOTS*LANES*DW)'(req_datab);

  // Scan downwards so the requester closest to the rr pointer wins.
  always_comb begin
    int s;
    w_winner = r_rr;
    for (int k = N_REQ-1; k >= 0; k--) begin
      s = int'(r_rr) + k;
      if (s >= N_REQ) s = s - N_REQ;
      if (w_req_ext[s[OWN_W-1:0]]) w_winner = s[OWN_W-1:0];
    end
  end

  assign w_len_raw = w_len_arr[w_winner];

  always_comb begin
    if (w_len_raw == '0)
      w_len = LEN_W'(1);
    else if (w_len_raw > LEN_W'(MAX_LEN))
      w_len = LEN_W'(MAX_LEN);
    else
      w_len = w_len_raw;
  end

  // A finished burst drops back to IDLE, which arbitrates combinationally: no bubble.
  always_comb begin
    w_beat = 1'b0;
    w_src  = r_owner;
    w_last = 1'b0;
    if (rst && en) begin
      if (r_state == BURST) begin
        w_beat = 1'b1;
        w_last = (r_beats_left == LEN_W'(1));
      end else if (|req) begin
        w_beat = 1'b1;
        w_src  = w_winner;
        w_last = (w_len == LEN_W'(1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_rr         <= '0;
      r_owner      <= '0;
      r_beats_left <= '0;
      r_dataa      <= '0;
      r_datab      <= '0;
    end else if (en) begin
      r_dataa <= w_beat ? w_dataa_arr[w_src] : '0;
      r_datab <= w_beat ? w_datab_arr[w_src] : '0;
      if (w_beat && w_last)
        r_rr <= (w_src == OWN_W'(N_REQ-1)) ? '0 : w_src + OWN_W'(1);
      if (r_state == BURST) begin
        if (w_last)
          r_state <= IDLE;
        else
          r_beats_left <= r_beats_left - LEN_W'(1);
      end else if (w_beat && !w_last) begin
        r_state      <= BURST;
        r_owner      <= w_winner;
        r_beats_left <= w_len - LEN_W'(1);
      end
    end
  end

  assign w_tag_in = '{valid: w_beat, owner: w_src, last: w_last};

  mult_tag_pipe #(
    .DEPTH(MULT_LAT + 1)
  ) u_tag_pipe (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .i_tag(w_tag_in),
    .o_tag(w_tag_out)
  );

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign grant[gi]     = w_beat && (w_src == OWN_W'(gi));
      assign res_valid[gi] = en && w_tag_out.valid && (w_tag_out.owner == OWN_W'(gi));
    end
  endgenerate

  assign res_last   = en && w_tag_out.valid && w_tag_out.last;
  assign res_data   = mult_result;
  assign mult_dataa = r_dataa;
  assign mult_datab = r_datab;

  logic [N_REQ-1:0] w_owner_mask;
  assign w_owner_mask = N_REQ'(1) << r_owner;

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(grant));
  a_res_onehot:   assert property (@(posedge clk) disable iff (!rst) $onehot0(res_valid));
  a_burst_owner:  assert property (@(posedge clk) disable iff (!rst)
                    (r_state == BURST) |-> ((grant & ~w_owner_mask) == '0));

endmodule

// File: tb/tb_mult_lane_arbiter.sv
// Directed bench for mult_lane_arbiter with a Q16 multiplier model of latency 4.
// Single-requester bursts come from a table; contention and reset are hand sequences.
module tb_mult_lane_arbiter;

  localparam int N_REQ = 4;
  localparam int LN    = 6;
  localparam int W     = 36;
  localparam int VW    = LN * W;
  localparam int LW    = 4;

  logic              clk;
  logic              rst;
  logic              en;
  logic [N_REQ-1:0]  req;
  logic [N_REQ*LW-1:0] req_len;
  logic [N_REQ*VW-1:0] req_dataa;
  logic [N_REQ*VW-1:0] req_datab;
  logic [N_REQ-1:0]  grant;
  logic [VW-1:0]     mult_dataa;
  logic [VW-1:0]     mult_datab;
  logic [VW-1:0]     mult_result;
  logic [VW-1:0]     res_data;
  logic [N_REQ-1:0]  res_valid;
  logic              res_last;

  int checks = 0;
  int errors = 0;

  mult_lane_arbiter #(
    .N_REQ(N_REQ), .MULT_LAT(4), .MAX_LEN(8)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .req_len(req_len),
    .req_dataa(req_dataa), .req_datab(req_datab), .grant(grant),
    .mult_dataa(mult_dataa), .mult_datab(mult_datab), .mult_result(mult_result),
    .res_data(res_data), .res_valid(res_valid), .res_last(res_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] q16mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] p;
    p = $signed(a) * $signed(b);
    return p[W+15:16];
  endfunction

  // Multiplier model: four en-qualified stages after the registered operands.
  logic [VW-1:0] m_pipe [4];
  always @(posedge clk) begin
    if (en) begin
      for (int l = 0; l < LN; l++)
        m_pipe[0][l*W +: W] <= q16mul(mult_dataa[l*W +: W], mult_datab[l*W +: W]);
      for (int k = 1; k < 4; k++)
        m_pipe[k] <= m_pipe[k-1];
    end
  end
  assign mult_result = m_pipe[3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int          idx;
    int          len;
    logic [W-1:0] b;
    int          beats;
    int          req_cyc;
    int          stall_at;
    logic [W-1:0] exp0;
  } vec_t;

  task automatic drive_ops(input int idx, input int e, input logic [W-1:0] b);
    req_dataa = '0;
    req_datab = '0;
    for (int l = 0; l < LN; l++) begin
      req_dataa[(idx*LN+l)*W +: W] = W'((e + 2 + l) * 65536);
      req_datab[(idx*LN+l)*W +: W] = b;
    end
  endtask

  // Walks one burst in en-cycles; stalled cycles must show nothing and freeze everything.
  task automatic run_burst(input vec_t v);
    int e = 0;
    int stall_left = (v.stall_at >= 0) ? 3 : 0;
    int total_e = v.beats + 8;
    logic [N_REQ-1:0] own;
    logic [63:0] prod;
    bit stall_now;
    own = N_REQ'(1) << v.idx;
    req_len = '0;
    req_len[v.idx*LW +: LW] = LW'(v.len);
    while (e < total_e) begin
      stall_now = (stall_left > 0) && (e == v.stall_at);
      en  = !stall_now;
      req = (e < v.req_cyc) ? own : '0;
      drive_ops(v.idx, e, v.b);
      @(negedge clk);
      if (stall_now) begin
        chk("stall_grant", 64'(grant), 64'(0));
        chk("stall_valid", 64'(res_valid), 64'(0));
        chk("stall_last", 64'(res_last), 64'(0));
        stall_left--;
      end else begin
        chk("grant", 64'(grant), (e < v.beats) ? 64'(own) : 64'(0));
        chk("res_valid", 64'(res_valid), (e >= 5 && e < 5 + v.beats) ? 64'(own) : 64'(0));
        chk("res_last", 64'(res_last), (e == 4 + v.beats) ? 64'(1) : 64'(0));
        if (e >= 1 && e <= v.beats)
          chk("mult_dataa0", 64'(mult_dataa[W-1:0]), 64'((e + 1) * 65536));
        else if (e == v.beats + 1)
          chk("mult_dataa_idle", 64'(mult_dataa[W-1:0]), 64'(0));
        if (e == 5)
          chk("res_lane0_first", 64'(res_data[W-1:0]), 64'(v.exp0));
        if (e >= 5 && e < 5 + v.beats) begin
          for (int l = 0; l < LN; l++) begin
            prod = 64'(e - 5 + 2 + l) * 64'(v.b);
            chk("res_lane", 64'(res_data[l*W +: W]), 64'(prod[W-1:0]));
          end
        end
        e++;
      end
      @(posedge clk);
      #1;
    end
    req = '0;
    en  = 1'b1;
    $display("burst req%0d len=%0d beats=%0d stall_at=%0d req_cyc=%0d checked",
             v.idx, v.len, v.beats, v.stall_at, v.req_cyc);
  endtask

  vec_t tbl[6];
  vec_t vr;
  logic [3:0] exp_seq [16];

  initial begin
    tbl[0] = '{idx: 1, len: 6,  b: 36'd196608, beats: 6, req_cyc: 6, stall_at: -1, exp0: 36'd393216};
    tbl[1] = '{idx: 0, len: 0,  b: 36'd65536,  beats: 1, req_cyc: 1, stall_at: -1, exp0: 36'd131072};
    tbl[2] = '{idx: 3, len: 15, b: 36'd32768,  beats: 8, req_cyc: 8, stall_at: -1, exp0: 36'd65536};
    tbl[3] = '{idx: 2, len: 4,  b: 36'd196608, beats: 4, req_cyc: 1, stall_at: -1, exp0: 36'd393216};
    tbl[4] = '{idx: 1, len: 5,  b: 36'd131072, beats: 5, req_cyc: 5, stall_at: 2,  exp0: 36'd262144};
    tbl[5] = '{idx: 2, len: 1,  b: 36'd98304,  beats: 1, req_cyc: 1, stall_at: -1, exp0: 36'd196608};
    exp_seq = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8,
                4'h1, 4'h1, 4'h4, 4'h4, 4'h1, 4'h1, 4'h4, 4'h4};

    rst = 1'b0; en = 1'b1; req = '0; req_len = '0; req_dataa = '0; req_datab = '0;
    for (int k = 0; k < 4; k++) m_pipe[k] = '0;
    #2;
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_valid", 64'(res_valid), 64'(0));
    chk("rst_last", 64'(res_last), 64'(0));
    chk("rst_dataa", 64'(mult_dataa[63:0]), 64'(0));
    chk("rst_datab", 64'(mult_datab[63:0]), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;

    // Contention from reset: all four len 2, then only 0 and 2.
    req_len = {4'd2, 4'd2, 4'd2, 4'd2};
    for (int c = 0; c < 22; c++) begin
      req = (c < 8) ? 4'b1111 : ((c < 16) ? 4'b0101 : 4'b0000);
      @(negedge clk);
      chk("cont_grant", 64'(grant), (c < 16) ? 64'(exp_seq[c]) : 64'(0));
      chk("cont_valid", 64'(res_valid), (c >= 5 && c < 21) ? 64'(exp_seq[c-5]) : 64'(0));
      @(posedge clk); #1;
    end
    req = '0;
    $display("contention sequence checked");

    for (int i = 0; i < 6; i++) run_burst(tbl[i]);

    // Reset with three beats of an 8-beat burst in flight.
    req_len = '0;
    req_len[1*LW +: LW] = 4'd8;
    req = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      drive_ops(1, c, 36'd65536);
      @(negedge clk);
      chk("pre_rst_grant", 64'(grant), 64'(4'b0010));
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    chk("rst_mid_grant", 64'(grant), 64'(0));
    chk("rst_mid_valid", 64'(res_valid), 64'(0));
    @(negedge clk);
    chk("rst_hold_grant", 64'(grant), 64'(0));
    chk("rst_hold_last", 64'(res_last), 64'(0));
    @(posedge clk); #1;
    req = '0;
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("no_stale_valid", 64'(res_valid), 64'(0));
      chk("no_stale_grant", 64'(grant), 64'(0));
      @(posedge clk); #1;
    end
    $display("reset mid-burst checked");
    vr = '{idx: 3, len: 1, b: 36'd327680, beats: 1, req_cyc: 1, stall_at: -1, exp0: 36'd655360};
    run_burst(vr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
